// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the RV32 immediate encoder: word size, format codes,
// field bit positions and the signed-range helper used by the packer.
package imm_encoder_pkg;

  localparam int WORDSIZE = 32;

  typedef enum logic [1:0] {
    EXTNR_R = 2'd0,
    EXTNR_I = 2'd1,
    EXTNR_S = 2'd2,
    EXTNR_B = 2'd3
  } fmt_e;

  // Field offsets within an RV32 instruction word.
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;
  localparam int IMM_I_LSB  = 20;
  localparam int IMM_HI_LSB = 25;
  localparam int IMM_LO_LSB = 7;

  // Significant immediate widths, including the sign bit.
  localparam int IMM_IS_BITS = 12;
  localparam int IMM_B_BITS  = 13;

  typedef struct packed {
    fmt_e                fmt;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [WORDSIZE-1:0] imm;
  } fields_t;

  // True when imm[WORDSIZE-1:bits-1] are all equal, i.e. imm fits in 'bits' signed bits.
  function automatic logic imm_fits(input logic [WORDSIZE-1:0] imm, input int bits);
    logic [WORDSIZE-1:0] upper;
    upper = WORDSIZE'($signed(imm) >>> (bits - 1));
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters decoded fields and the immediate into the
// R/I/S/B layout and flags out-of-range or misaligned immediates.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [1:0]          fmt,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [WORDSIZE-1:0] imm,
  output logic [WORDSIZE-1:0] word,
  output logic                err
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    word = '0;
    err  = 1'b0;
    word[OPCODE_LSB +: 7] = opcode;
    word[FUNCT3_LSB +: 3] = funct3;
    word[RS1_LSB    +: 5] = rs1;
    case (fmt_e'(fmt))
      EXTNR_R: begin
        word[RD_LSB     +: 5] = rd;
        word[RS2_LSB    +: 5] = rs2;
        word[FUNCT7_LSB +: 7] = funct7;
      end
      EXTNR_I: begin
        word[RD_LSB    +: 5]  = rd;
        word[IMM_I_LSB +: 12] = imm[11:0];
        err = !imm_fits(imm, IMM_IS_BITS);
      end
      EXTNR_S: begin
        word[RS2_LSB    +: 5] = rs2;
        word[IMM_HI_LSB +: 7] = imm[11:5];
        word[IMM_LO_LSB +: 5] = imm[4:0];
        err = !imm_fits(imm, IMM_IS_BITS);
      end
      EXTNR_B: begin
        word[RS2_LSB +: 5] = rs2;
        word[31]           = imm[12];
        word[30:25]        = imm[10:5];
        word[11:8]         = imm[4:1];
        word[7]            = imm[11];
        err = !imm_fits(imm, IMM_B_BITS) || imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready instruction encoder with delivery statistics:
// S1 holds the raw fields, S2 holds the packed word that drives the outputs.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          fmt,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [WORDSIZE-1:0] imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_instr,
  output logic                out_err,
  output logic [CNT_W-1:0]    enc_count,
  output logic [7:0]          err_count
);

  fields_t             s1_q;
  logic                s1_valid;
  logic                s1_advance;
  logic                s2_advance;
  logic                out_fire;
  logic [WORDSIZE-1:0] pack_word;
  logic                pack_err;

  // Ready ripples back combinationally so a full pipe still moves one word per cycle.
  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = s1_advance;
  assign out_fire   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      // NOTE: the field register is reset too; it is small and keeps X out of the packer.
      s1_q     <= '0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= '{fmt: fmt_e'(fmt), opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                  funct3: funct3, funct7: funct7, imm: imm};
      end
    end
  end

  imm_pack u_pack (
    .fmt    (s1_q.fmt),
    .opcode (s1_q.opcode),
    .rd     (s1_q.rd),
    .rs1    (s1_q.rs1),
    .rs2    (s1_q.rs2),
    .funct3 (s1_q.funct3),
    .funct7 (s1_q.funct7),
    .imm    (s1_q.imm),
    .word   (pack_word),
    .err    (pack_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= pack_word;
        out_err   <= pack_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_fire) begin
      enc_count <= enc_count + CNT_W'(1);
      if (out_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vector table, error-counter
// saturation, backpressure, mid-stream reset and randomized traffic vs a model.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  localparam int CNT_W = 16;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic              out_err;
  logic [CNT_W-1:0]  enc_count;
  logic [7:0]        err_count;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [32:0] exp_q[$];
  int          hs_q[$];
  bit          strict_lat = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;
  int          m_enc = 0;
  int          m_err = 0;
  int          delivered = 0;
  logic [31:0] last_instr;
  logic        last_err;
  bit          last_in_hs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic longint at(input longint v, input int pos);
    return v * (longint'(1) << pos);
  endfunction

  // Reference encoder built from the format rules with plain integer arithmetic.
  function automatic logic [32:0] model(input logic [1:0] f, input logic [6:0] op,
                                        input logic [4:0] r_d, input logic [4:0] r_s1,
                                        input logic [4:0] r_s2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] im);
    longint s, u, w;
    logic   e;
    s = longint'($signed(im));
    w = longint'(op) + at(longint'(f3), 12) + at(longint'(r_s1), 15);
    e = 1'b0;
    case (f)
      EXTNR_R: w += at(longint'(r_d), 7) + at(longint'(r_s2), 20) + at(longint'(f7), 25);
      EXTNR_I: begin
        u = ((s % 4096) + 4096) % 4096;
        w += at(longint'(r_d), 7) + at(u, 20);
        e = (s < -2048) || (s > 2047);
      end
      EXTNR_S: begin
        u = ((s % 4096) + 4096) % 4096;
        w += at(longint'(r_s2), 20) + at(u / 32, 25) + at(u % 32, 7);
        e = (s < -2048) || (s > 2047);
      end
      default: begin
        u = ((s % 8192) + 8192) % 8192;
        w += at(longint'(r_s2), 20) + at(u / 4096, 31) + at((u / 32) % 64, 25)
           + at((u / 2) % 16, 8) + at((u / 2048) % 2, 7);
        e = (s < -4096) || (s > 4094) || (u % 2 == 1);
      end
    endcase
    return {e, w[31:0]};
  endfunction

  // One clock cycle: sample at the falling edge, score outputs, log input handshake.
  task automatic step();
    logic [32:0] e;
    int          lat;
    @(negedge clk);
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_instr", out_instr, prev_instr);
      check("hold_err", out_err, prev_err);
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        if (!prev_stall) begin
          lat = cyc - hs_q[0];
          if (strict_lat) check("latency", lat, 2);
          else            check("latency_min", (lat >= 2), 1);
        end
        if (out_ready) begin
          e = exp_q.pop_front();
          void'(hs_q.pop_front());
          check("instr", out_instr, e[31:0]);
          check("err", out_err, e[32]);
          last_instr = out_instr;
          last_err   = out_err;
          delivered++;
          m_enc = (m_enc + 1) % 65536;
          if (e[32] && m_err < 255) m_err++;
        end
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_instr = out_instr;
    prev_err   = out_err;
    last_in_hs = in_valid && in_ready;
    if (last_in_hs) begin
      exp_q.push_back(model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
      hs_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_enc_count"}, enc_count, m_enc[15:0]);
    check({tag, "_err_count"}, err_count, m_err[7:0]);
  endtask

  // Asynchronous reset asserted between clock edges; released just after an edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_enc_count", enc_count, 0);
    check("rst_err_count", err_count, 0);
    exp_q.delete();
    hs_q.delete();
    prev_stall = 1'b0;
    m_enc = 0;
    m_err = 0;
    delivered = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
  endtask

  function automatic logic [31:0] rand_imm();
    int edges[14];
    edges = '{-4097, -4096, -4095, -2049, -2048, -2047, -1, 0, 2046, 2047, 2048, 4094, 4095, 4096};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'(int'($urandom_range(0, 8191)) - 4096);
      default: return 32'(edges[$urandom_range(0, 13)]);
    endcase
  endfunction

  task automatic rand_fields();
    fmt    = 2'($urandom_range(0, 3));
    opcode = 7'($urandom);
    rd     = 5'($urandom);
    rs1    = 5'($urandom);
    rs2    = 5'($urandom);
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
    imm    = rand_imm();
  endtask

  typedef struct {
    logic [1:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int sent;
    bit pending;

    vecs[0] = '{EXTNR_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,     32'h00500093, 1'b0};
    vecs[1] = '{EXTNR_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,     32'h0020A423, 1'b0};
    vecs[2] = '{EXTNR_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,     32'h002081B3, 1'b0};
    vecs[3] = '{EXTNR_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4,   32'hFE000EE3, 1'b0};
    vecs[4] = '{EXTNR_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,     32'h00000163, 1'b1};
    vecs[5] = '{EXTNR_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,  32'h80000063, 1'b1};
    vecs[6] = '{EXTNR_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,  32'h80000093, 1'b1};
    vecs[7] = '{EXTNR_S, 7'h23, 5'd0, 5'd0, 5'd0, 3'd2, 7'd0, -32'sd2048, 32'h80002023, 1'b0};
    vecs[8] = '{EXTNR_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,  32'h7E000FE3, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    #12;
    check("por_out_valid", out_valid, 0);
    check("por_out_instr", out_instr, 0);
    check("por_out_err", out_err, 0);
    check("por_enc_count", enc_count, 0);
    check("por_err_count", err_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("por_in_ready", in_ready, 1);

    // Directed vectors, one at a time, with strict two-cycle latency.
    strict_lat = 1'b1;
    out_ready  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      fmt = vecs[i].fmt; opcode = vecs[i].op; rd = vecs[i].rd; rs1 = vecs[i].rs1;
      rs2 = vecs[i].rs2; funct3 = vecs[i].f3; funct7 = vecs[i].f7; imm = vecs[i].imm;
      in_valid = 1'b1;
      step();
      check($sformatf("vec%0d_accept", i), last_in_hs, 1);
      drain();
      check($sformatf("vec%0d_instr", i), last_instr, vecs[i].instr);
      check($sformatf("vec%0d_err", i), last_err, vecs[i].err);
    end
    check_counts("vec");

    // 300 out-of-range I words back to back: err_count must pin at 255.
    fmt = EXTNR_I; opcode = 7'h13; rd = 5'd1; rs1 = '0; funct3 = '0; imm = 32'd2048;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    drain();
    check("sat_err_count", err_count, 255);
    check_counts("sat");

    // Eight words under random backpressure.
    apply_reset();
    strict_lat = 1'b0;
    sent = 0;
    rand_fields();
    in_valid = 1'b1;
    for (int c = 0; c < 200 && sent < 8; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (last_in_hs) begin
        sent++;
        if (sent < 8) rand_fields();
        else          in_valid = 1'b0;
      end
    end
    check("bp_sent", sent, 8);
    drain();
    check("bp_delivered", delivered, 8);
    check("bp_enc_count", enc_count, 8);

    // Fill both stages, then reset mid-stream: nothing old may emerge afterwards.
    out_ready = 1'b0;
    sent = 0;
    rand_fields();
    in_valid = 1'b1;
    for (int c = 0; c < 10 && sent < 2; c++) begin
      step();
      if (last_in_hs) begin
        sent++;
        rand_fields();
      end
    end
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    apply_reset();
    strict_lat = 1'b1;
    out_ready  = 1'b1;
    rand_fields();
    in_valid = 1'b1;
    step();
    check("post_rst_accept", last_in_hs, 1);
    drain();
    check("post_rst_delivered", delivered, 1);

    // Random traffic with random stalls against the reference model.
    strict_lat = 1'b0;
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        rand_fields();
        pending = 1'b1;
      end
      in_valid  = pending;
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      if (last_in_hs) pending = 1'b0;
    end
    drain();
    check_counts("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
